key_byte_fifo: RTL and testbench
================================

Name: key_byte_fifo

Overview:
- Buffers the single-cycle valid/data byte strobes produced by the debounced button/switch capture stage.
- Gives a downstream consumer (display scanner, UART TX, calculator core) a show-ahead valid/ready read interface.
- Decouples one-byte-at-a-time human entry from a consumer that drains in bursts or stalls.
- Reports occupancy and full/empty status, and keeps a sticky overflow flag.

Parameters:
- DW, 8, data width in bits; matches the switch byte width.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset
- in_valid  input  1  one-cycle write strobe from the capture stage
- in_data  input  DW  byte written when in_valid=1
- out_valid  output  1  head entry available (=~empty)
- out_data  output  DW  head entry; 0 when empty
- out_ready  input  1  consumer accepts the head this cycle
- count  output  AW+1  current occupancy, 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0
- overflow  output  1  sticky: a write was lost (or overwrote data, see optional feature)
- ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Interface reset: rst, asynchronous, active-high; clock clk.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, out_valid=0, out_data=0, overflow=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Write accept: push = in_valid & (~full | pop).
  - On push: mem[wr_ptr] <= in_data, and wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Read accept: pop = out_valid & out_ready.
  - On pop: rd_ptr increments modulo DEPTH.
  - out_ready while empty has no effect.
- Show-ahead read:
  - out_data = mem[rd_ptr], combinational from the registered pointer, gated to 0 when empty.
  - A byte written in cycle N is visible on out_data/out_valid in cycle N+1; write-to-read latency is 1 clk.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- full, empty and count are registered or derived from registered state only. None depend combinationally on in_valid.
- Boundary cases:
  - Full, in_valid=1, out_ready=0: the write is dropped, overflow <= 1, and pointers and count are unchanged.
  - Full, in_valid=1, out_ready=1: pop and push both occur in the same cycle; count stays DEPTH and no overflow.
  - Empty, in_valid=1, out_ready=1: push only; the entry appears next cycle. There is no combinational bypass.
  - Pointer wrap: after DEPTH pushes wr_ptr returns to 0. full/empty are distinguished by count, not by the pointers.
- Overflow flag:
  - Set on any dropped write; it stays set until ovf_clr=1 or rst.
  - If a drop and ovf_clr occur in the same cycle, set wins and overflow remains 1.
- Upstream cannot back-pressure the capture stage. A dropped byte is reported only through overflow.

Optional Feature:
- Macro: KEY_BYTE_FIFO_DROP_OLDEST_EN.
- Defined: a write when full with no pop overwrites the oldest entry instead of being dropped.
  - mem[wr_ptr] <= in_data; wr_ptr and rd_ptr both increment; count stays DEPTH; overflow <= 1.
  - The FIFO always holds the most recent DEPTH bytes.
- Undefined (default): the new byte is dropped as described in Behaviour.

Test Plan:
- Reset/idle: assert rst mid-sim with 3 entries stored -> the same cycle shows count=0, empty=1, out_valid=0, out_data=0, overflow=0.
- Single pass-through: in_valid pulse with in_data=8'hA5 while out_ready=0.
  - Next cycle: out_valid=1, out_data=A5, count=1.
  - Then out_ready=1 for 1 cycle -> empty=1 and count=0 next cycle.
- Fill and wrap: write 8'h01..8'h08 -> full=1, count=8.
  - Drain with out_ready held high -> reads 01..08 in order.
  - Then write 8'h09, 8'h0A -> the pointers have wrapped and the reads return 09, 0A.
- Overflow (default build): fill with 10..17, then write 8'hFF with out_ready=0.
  - Result: count=8, overflow=1, drain yields 10..17 and FF never appears.
  - Then ovf_clr=1 -> overflow=0 next cycle.
- Simultaneous at full: full with head=8'h20, in_valid=1 with in_data=8'h30 and out_ready=1 in the same cycle.
  - Result: count stays 8, overflow stays 0, next head=8'h21, and 30 is read last.
- Drop-oldest build (KEY_BYTE_FIFO_DROP_OLDEST_EN): fill with 10..17, then write 8'hFF with out_ready=0.
  - Result: overflow=1, count=8, drain yields 11..17 followed by FF.
  - Additionally: ovf_clr held high during an overwrite -> overflow still reads 1.

Source files
------------

// File: rtl/key_byte_fifo.sv
// Show-ahead byte FIFO that sits between the key/switch capture stage and its consumer.
// Define KEY_BYTE_FIFO_DROP_OLDEST_EN to make a write into a full FIFO overwrite the oldest byte.
module key_byte_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   input  logic          ovf_clr
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;

   logic push, pop, drop, ovw, inc;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;

   always_comb begin
      pop = out_valid & out_ready;
`ifdef KEY_BYTE_FIFO_DROP_OLDEST_EN
      push = in_valid;
      drop = 1'b0;
      ovw  = in_valid & full & ~pop;
`else
      push = in_valid & (~full | pop);
      drop = in_valid & full & ~pop;
      ovw  = 1'b0;
`endif
      // An overwrite retires the oldest byte, so occupancy does not grow.
      inc = push & ~ovw;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = (pop | ovw) ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      if (inc && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !inc) begin
         count_d = count_q - 1'b1;
      end

      overflow_d = overflow_q;
      if (drop || ovw) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_key_byte_fifo.sv
// Bench for key_byte_fifo: directed scenarios plus random traffic against a queue reference.
module tb_key_byte_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic [3:0]    count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          ovf_clr = 1'b0;

   always #5 clk = ~clk;

   key_byte_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   // Reference: FIFO contents oldest-first, plus the sticky flag.
   logic [DW-1:0] q[$];
   bit            ovf_m = 1'b0;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      logic [DW-1:0] head;
      head = (q.size() != 0) ? q[0] : '0;
      chk({tag, "_count"}, 32'(count), 32'(q.size()));
      chk({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
      chk({tag, "_out_data"}, 32'(out_data), 32'(head));
      chk({tag, "_overflow"}, 32'(overflow), 32'(ovf_m));
   endtask

   // Called at posedge+1; applies one cycle of stimulus, predicts, then checks after the edge.
   task automatic step(input string tag, input bit v, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
      bit pop_m;
      bit lost;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      ovf_clr   = clr;
      pop_m = (q.size() != 0) && rdy;
      lost  = 1'b0;
      if (v) begin
         if (q.size() < DEPTH || pop_m) begin
            q.push_back(d);
         end else begin
            lost = 1'b1;
`ifdef KEY_BYTE_FIFO_DROP_OLDEST_EN
            void'(q.pop_front());
            q.push_back(d);
`endif
         end
      end
      if (lost) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      check_state(tag);
   endtask

   // Monitor: every accepted head byte must match the oldest predicted byte.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h expected no data at %0t", out_data, $time);
         end else begin
            logic [DW-1:0] exp_b;
            exp_b = q.pop_front();
            chk("sb_data", 32'(out_data), 32'(exp_b));
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_state("reset");

      // Single pass-through
      step("pt_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
      step("pt_rd", 1'b0, 8'h00, 1'b1, 1'b0);

      // Fill, drain, then wrap the pointers
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      repeat (8) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      step("wrap_wr", 1'b1, 8'h09, 1'b0, 1'b0);
      step("wrap_wr", 1'b1, 8'h0A, 1'b0, 1'b0);
      repeat (2) step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);

      // Write into a full FIFO with no pop, then clear the flag
      for (int i = 0; i < 8; i++) step("ovf_fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step("ovf_wr", 1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      repeat (8) step("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

      // Lost write with ovf_clr in the same cycle: set must win
      for (int i = 0; i < 8; i++) step("sw_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step("set_wins", 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("set_wins_flag", 32'(overflow), 32'd1);

      // Reset with 3 entries stored and overflow set
      repeat (5) step("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_full", 32'(full), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      q.delete();
      ovf_m = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_state("post_rst");

      // Push and pop together at full
      for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step("sim_full", 1'b1, 8'h30, 1'b1, 1'b0);
      chk("sim_head", 32'(out_data), 32'h21);
      repeat (8) step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Empty FIFO with write and ready together: no bypass
      step("no_bypass", 1'b1, 8'h5A, 1'b1, 1'b0);
      step("no_bypass_rd", 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic: a fill-biased phase then a drain-biased phase
      for (int n = 0; n < 300; n++) begin
         step("rnd_a", $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0);
      end
      for (int n = 0; n < 300; n++) begin
         step("rnd_b", $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);
      end
      repeat (DEPTH + 2) step("final_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("final_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
